dma_io_device_responder: RTL and testbench

//  Peripheral-side endpoint of the DMA channel handshake: the I/O device that raises DREQ,

---
 rtl/dmaRegConfigPkg.sv | 13 +
 rtl/dma_dev_fifo.sv | 47 ++++
 rtl/dma_io_device_responder.sv | 156 +++++++++++++++
 tb/tb_dma_io_device_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmaRegConfigPkg.sv
// Shared definitions for the DMA I/O device responder: bus width and the channel state type.
package dmaRegConfigPkg;

  localparam int DATAWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } devState_t;

endpackage

// File: rtl/dma_dev_fifo.sv
// Synchronous FIFO for the DMA device buffer; full/empty come from pointers carrying an extra wrap bit.
module dma_dev_fifo #(
  parameter int DATAWIDTH  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [DATAWIDTH-1:0]          i_push_data,
  input  logic                          i_pop,
  output logic [DATAWIDTH-1:0]          o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATAWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  // A push into a full buffer is dropped even if a pop lands the same cycle.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/dma_io_device_responder.sv
// Peripheral end of a DREQ/DACK channel: sources or sinks one byte per IOR_N/IOW_N strobe,
// bridging the DMA bus to a local valid/ready port through a small FIFO.
//
//   state | meaning
//   IDLE  | channel disarmed, DREQ low, dir may change
//   ARMED | requesting service, DACK not yet asserted
//   XFER  | DACK asserted, strobes move data
//   DONE  | EOP seen, DREQ low until enable drops
module dma_io_device_responder #(
  parameter int DATAWIDTH  = dmaRegConfigPkg::DATAWIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int CNTWIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  output logic                 DREQ,
  input  logic                 DACK,
  input  logic                 IOR_N,
  input  logic                 IOW_N,
  inout  wire                  EOP_N,
  inout  wire  [DATAWIDTH-1:0] DB,
  input  logic                 enable,
  input  logic                 dir,
  input  logic                 last_req,
  input  logic                 src_valid,
  input  logic [DATAWIDTH-1:0] src_data,
  output logic                 src_ready,
  output logic                 snk_valid,
  output logic [DATAWIDTH-1:0] snk_data,
  input  logic                 snk_ready,
  output logic                 tc_pulse,
  output logic [CNTWIDTH-1:0]  xfer_count
);

  import dmaRegConfigPkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);

  devState_t            r_state;
  devState_t            w_state_nxt;
  logic                 r_dir;
  logic                 r_ior_q;
  logic                 r_iow_q;
  logic                 r_dack_q;
  logic                 r_dreq;
  logic                 r_tc;
  logic                 r_out_en;
  logic [CNTWIDTH-1:0]  r_xfer_cnt;
  logic [DATAWIDTH-1:0] r_db_smp;

  logic                 w_dir;
  logic                 w_active;
  logic                 w_busy;
  logic                 w_ior_rise;
  logic                 w_iow_rise;
  logic                 w_eop_seen;
  logic                 w_db_oe;
  logic                 w_eop_oe;
  logic                 w_push;
  logic                 w_pop;
  logic [DATAWIDTH-1:0] w_push_data;
  logic [DATAWIDTH-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [AW:0]          w_count;

  // Direction is only followed while idle; once armed the latched copy rules.
  assign w_dir      = (r_state == IDLE) ? dir : r_dir;
  assign w_active   = (r_state != IDLE);
  assign w_busy     = (r_state == ARMED) || (r_state == XFER);
  assign w_eop_seen = !EOP_N && !DACK;

  // Strobe qualification uses DACK as it was during the low phase of the strobe.
  assign w_ior_rise = !r_ior_q && IOR_N && !r_dack_q && w_active && !w_dir;
  assign w_iow_rise = !r_iow_q && IOW_N && !r_dack_q && w_active && w_dir;

  assign w_db_oe  = w_active && !DACK && !IOR_N && !w_dir;
  assign w_eop_oe = w_db_oe && last_req && (w_count == (AW+1)'(1));
  assign DB       = w_db_oe ? w_head : {DATAWIDTH{1'bz}};
  assign EOP_N    = w_eop_oe ? 1'b0 : 1'bz;

  assign src_ready  = r_out_en && !w_full && !w_dir;
  assign snk_valid  = r_out_en && !w_empty && w_dir;
  assign snk_data   = w_head;
  assign DREQ       = r_dreq;
  assign tc_pulse   = r_tc;
  assign xfer_count = r_xfer_cnt;

  assign w_push      = w_iow_rise || (src_valid && src_ready);
  assign w_pop       = w_ior_rise || (snk_valid && snk_ready);
  assign w_push_data = w_dir ? r_db_smp : src_data;

  dma_dev_fifo #(
    .DATAWIDTH  (DATAWIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (CLK),
    .i_rst_n     (RESET_N),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = ARMED;
      ARMED: begin
        if (!enable)         w_state_nxt = IDLE;
        else if (w_eop_seen) w_state_nxt = DONE;
        else if (!DACK)      w_state_nxt = XFER;
      end
      XFER: begin
        if (!enable)         w_state_nxt = IDLE;
        else if (w_eop_seen) w_state_nxt = DONE;
        else if (DACK)       w_state_nxt = ARMED;
      end
      DONE:    if (!enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_ior_q    <= 1'b1;
      r_iow_q    <= 1'b1;
      r_dack_q   <= 1'b1;
      r_dreq     <= 1'b0;
      r_tc       <= 1'b0;
      r_out_en   <= 1'b0;
      r_xfer_cnt <= '0;
      r_db_smp   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir;
      r_ior_q  <= IOR_N;
      r_iow_q  <= IOW_N;
      r_dack_q <= DACK;
      r_out_en <= 1'b1;
      r_dreq   <= w_busy && (w_dir ? !w_full : !w_empty);
      r_tc     <= w_busy && (w_state_nxt == DONE);
      if (!IOW_N) r_db_smp <= DB;
      if ((r_state == IDLE) && enable)
        r_xfer_cnt <= '0;
      else if ((w_ior_rise || w_iow_rise) && (r_xfer_cnt != '1))
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_io_device_responder.sv
// Bench for the DMA device responder: directed handshake scenarios plus randomized
// source/sink bursts checked against a queue model of the buffer.
module tb_dma_io_device_responder;

  localparam int DW  = 8;
  localparam int CW  = 4;

  logic          CLK;
  logic          RESET_N;
  logic          DREQ;
  logic          DACK;
  logic          IOR_N;
  logic          IOW_N;
  wire           EOP_N;
  wire  [DW-1:0] DB;
  logic          enable;
  logic          dir;
  logic          last_req;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          snk_valid;
  logic [DW-1:0] snk_data;
  logic          snk_ready;
  logic          tc_pulse;
  logic [CW-1:0] xfer_count;

  logic          tb_db_oe;
  logic [DW-1:0] tb_db;
  logic          tb_eop;

  int n_checks = 0;
  int n_fails  = 0;
  int tc_seen  = 0;

  assign DB    = tb_db_oe ? tb_db : {DW{1'bz}};
  assign EOP_N = tb_eop ? 1'b0 : 1'bz;
  pullup (EOP_N);

  dma_io_device_responder #(.FIFO_DEPTH(8), .CNTWIDTH(CW)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .DREQ       (DREQ),
    .DACK       (DACK),
    .IOR_N      (IOR_N),
    .IOW_N      (IOW_N),
    .EOP_N      (EOP_N),
    .DB         (DB),
    .enable     (enable),
    .dir        (dir),
    .last_req   (last_req),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .snk_valid  (snk_valid),
    .snk_data   (snk_data),
    .snk_ready  (snk_ready),
    .tc_pulse   (tc_pulse),
    .xfer_count (xfer_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (tc_pulse === 1'b1) tc_seen++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic local_push(input logic [DW-1:0] v);
    check_val("src_ready", {31'd0, src_ready}, 32'd1);
    src_valid = 1'b1;
    src_data  = v;
    tick();
    src_valid = 1'b0;
  endtask

  task automatic local_pop(output logic [DW-1:0] v);
    check_val("snk_valid", {31'd0, snk_valid}, 32'd1);
    v = snk_data;
    snk_ready = 1'b1;
    tick();
    snk_ready = 1'b0;
  endtask

  task automatic dma_read(output logic [DW-1:0] v);
    DACK  = 1'b0;
    IOR_N = 1'b0;
    tick();
    v = DB;
    IOR_N = 1'b1;
    tick();
    DACK = 1'b1;
  endtask

  task automatic dma_write(input logic [DW-1:0] v);
    DACK     = 1'b0;
    IOW_N    = 1'b0;
    tb_db_oe = 1'b1;
    tb_db    = v;
    tick();
    IOW_N    = 1'b1;
    tb_db_oe = 1'b0;
    tick();
    DACK = 1'b1;
  endtask

  task automatic wait_dreq();
    for (int i = 0; i < 8; i++) begin
      if (DREQ === 1'b1) break;
      tick();
    end
    check_val("dreq_wait", {31'd0, DREQ}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] q[$];
    int            tc_base;
    int            n;

    RESET_N = 1'b0; DACK = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1;
    enable = 1'b0; dir = 1'b0; last_req = 1'b0;
    src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
    tb_db_oe = 1'b0; tb_db = '0; tb_eop = 1'b0;
    #12;
    check_val("rst_dreq",      {31'd0, DREQ},      32'd0);
    check_val("rst_tc",        {31'd0, tc_pulse},  32'd0);
    check_val("rst_xfer_cnt",  {28'd0, xfer_count}, 32'd0);
    check_val("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check_val("rst_snk_valid", {31'd0, snk_valid}, 32'd0);
    check_val("rst_eop",       {31'd0, EOP_N},     32'd1);
    tick();
    RESET_N = 1'b1;
    tick();
    tick();

    // source mode: three bytes out over the DMA bus
    local_push(8'h11); local_push(8'h22); local_push(8'h33);
    enable = 1'b1;
    tick();
    tick();
    check_val("src_dreq_rise", {31'd0, DREQ}, 32'd1);
    dma_read(v); check_val("src_db0", {24'd0, v}, 32'h11);
    dma_read(v); check_val("src_db1", {24'd0, v}, 32'h22);
    dma_read(v); check_val("src_db2", {24'd0, v}, 32'h33);
    check_val("src_dreq_latency", {31'd0, DREQ}, 32'd1);
    tick();
    check_val("src_dreq_drop", {31'd0, DREQ}, 32'd0);
    check_val("src_xfer_cnt", {28'd0, xfer_count}, 32'd3);
    enable = 1'b0;
    tick();

    // sink mode: fill to depth, ninth strobe dropped
    dir = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    tick();
    check_val("snk_dreq_rise", {31'd0, DREQ}, 32'd1);
    for (int i = 0; i < 8; i++) dma_write(8'(i));
    check_val("snk_dreq_latency", {31'd0, DREQ}, 32'd1);
    tick();
    check_val("snk_dreq_full", {31'd0, DREQ}, 32'd0);
    dma_write(8'hEE);
    check_val("snk_xfer_cnt", {28'd0, xfer_count}, 32'd9);
    for (int i = 0; i < 8; i++) begin
      local_pop(v);
      check_val("snk_order", {24'd0, v}, i);
    end
    check_val("snk_empty", {31'd0, snk_valid}, 32'd0);
    enable = 1'b0;
    tick();

    // counter saturation: 17 strobes on a 4-bit counter
    enable = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 17; i++) dma_write(8'(i + 8'h40));
    check_val("cnt_saturate", {28'd0, xfer_count}, 32'd15);
    for (int i = 0; i < 8; i++) begin
      local_pop(v);
      check_val("sat_no_overwrite", {24'd0, v}, i + 32'h40);
    end
    enable = 1'b0;
    dir = 1'b0;
    tick();

    // own EOP on the byte that empties the buffer
    last_req = 1'b1;
    local_push(8'hA5);
    enable = 1'b1;
    tick();
    tick();
    tc_base = tc_seen;
    DACK  = 1'b0;
    IOR_N = 1'b0;
    tick();
    check_val("eop_drive", {31'd0, EOP_N}, 32'd0);
    check_val("eop_db", {24'd0, DB}, 32'hA5);
    IOR_N = 1'b1;
    tick();
    DACK = 1'b1;
    tick();
    tick();
    check_val("eop_tc_once", tc_seen - tc_base, 32'd1);
    check_val("eop_release", {31'd0, EOP_N}, 32'd1);
    last_req = 1'b0;
    local_push(8'h5A);
    tick();
    tick();
    tick();
    check_val("done_dreq_low", {31'd0, DREQ}, 32'd0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    tick();
    check_val("rearm_dreq", {31'd0, DREQ}, 32'd1);
    dma_read(v); check_val("rearm_db", {24'd0, v}, 32'h5A);
    enable = 1'b0;
    tick();

    // controller-driven EOP on the second of four transfers
    local_push(8'hC1); local_push(8'hC2); local_push(8'hC3); local_push(8'hC4);
    enable = 1'b1;
    tick();
    tick();
    tc_base = tc_seen;
    dma_read(v); check_val("ext_db0", {24'd0, v}, 32'hC1);
    DACK   = 1'b0;
    IOR_N  = 1'b0;
    tb_eop = 1'b1;
    tick();
    check_val("ext_db1", {24'd0, DB}, 32'hC2);
    IOR_N  = 1'b1;
    tb_eop = 1'b0;
    tick();
    DACK = 1'b1;
    tick();
    tick();
    check_val("ext_tc_once", tc_seen - tc_base, 32'd1);
    check_val("ext_dreq_low", {31'd0, DREQ}, 32'd0);
    check_val("ext_xfer_cnt", {28'd0, xfer_count}, 32'd2);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    tick();
    check_val("ext_left_dreq", {31'd0, DREQ}, 32'd1);
    dma_read(v); check_val("ext_left0", {24'd0, v}, 32'hC3);
    dma_read(v); check_val("ext_left1", {24'd0, v}, 32'hC4);
    tick();
    check_val("ext_left_empty", {31'd0, DREQ}, 32'd0);
    enable = 1'b0;
    tick();

    // strobes without DACK belong to the controller and must be ignored
    local_push(8'h77);
    enable = 1'b1;
    tick();
    tick();
    IOR_N    = 1'b0;
    tb_db_oe = 1'b1;
    tb_db    = 8'h00;
    tick();
    check_val("nodack_db_float", {24'd0, DB}, 32'h00);
    IOR_N    = 1'b1;
    tb_db_oe = 1'b0;
    tick();
    IOW_N = 1'b0;
    tick();
    IOW_N = 1'b1;
    tick();
    check_val("nodack_xfer_cnt", {28'd0, xfer_count}, 32'd0);
    check_val("nodack_dreq", {31'd0, DREQ}, 32'd1);
    dma_read(v); check_val("nodack_fifo", {24'd0, v}, 32'h77);
    check_val("nodack_after_cnt", {28'd0, xfer_count}, 32'd1);
    enable = 1'b0;
    tick();

    // reset in the middle of a read strobe
    local_push(8'h3C);
    local_push(8'h3D);
    enable = 1'b1;
    tick();
    tick();
    DACK  = 1'b0;
    IOR_N = 1'b0;
    tick();
    check_val("rst_mid_db_drive", {24'd0, DB}, 32'h3C);
    RESET_N  = 1'b0;
    tb_db_oe = 1'b1;
    tb_db    = 8'h00;
    #1;
    check_val("rst_mid_db_float", {24'd0, DB}, 32'h00);
    check_val("rst_mid_dreq", {31'd0, DREQ}, 32'd0);
    tb_db_oe = 1'b0;
    IOR_N    = 1'b1;
    DACK     = 1'b1;
    tick();
    RESET_N = 1'b1;
    tick();
    tick();
    tick();
    check_val("rst_mid_fifo_empty", {31'd0, DREQ}, 32'd0);
    check_val("rst_mid_xfer_cnt", {28'd0, xfer_count}, 32'd0);
    enable = 1'b0;
    tick();

    // randomized bursts against a queue model
    for (int it = 0; it < 10; it++) begin
      dir = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 8);
      q.delete();
      tick();
      if (dir == 1'b0) begin
        for (int i = 0; i < n; i++) begin
          v = 8'($urandom_range(0, 255));
          q.push_back(v);
          local_push(v);
        end
        enable = 1'b1;
        wait_dreq();
        for (int i = 0; i < n; i++) begin
          dma_read(v);
          check_val("rnd_src_db", {24'd0, v}, {24'd0, q.pop_front()});
        end
        tick();
        check_val("rnd_src_dreq_end", {31'd0, DREQ}, 32'd0);
      end else begin
        enable = 1'b1;
        wait_dreq();
        for (int i = 0; i < n; i++) begin
          v = 8'($urandom_range(0, 255));
          q.push_back(v);
          dma_write(v);
        end
        for (int i = 0; i < n; i++) begin
          local_pop(v);
          check_val("rnd_snk_data", {24'd0, v}, {24'd0, q.pop_front()});
        end
        check_val("rnd_snk_empty", {31'd0, snk_valid}, 32'd0);
      end
      check_val("rnd_xfer_cnt", {28'd0, xfer_count}, n);
      enable = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
